// File: rtl/gpi_pkg.sv
// Shared constants and sizing helpers for the general-purpose input conditioner.
`timescale 1ns/1ps
package gpi_pkg;

  // Cycles per 1 ms debounce tick at 48 MHz.
  localparam int unsigned TICKS_1MS_48MHZ = 48000;

  // The counter must hold DEBOUNCE_TICKS without wrapping.
  function automatic int unsigned cnt_width(input int unsigned ticks);
    return $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/gpi_debounce_if.sv
// Pin, level, edge and sticky-event bundle for the GPI debounce block.
`timescale 1ns/1ps
interface gpi_debounce_if #(
  parameter int unsigned N_CH = 1
);
  logic [N_CH-1:0] pin_i;
  logic [N_CH-1:0] evt_clr_i;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] rise_o;
  logic [N_CH-1:0] fall_o;
  logic [N_CH-1:0] evt_o;

  modport master (
    output pin_i,
    output evt_clr_i,
    input  level_o,
    input  rise_o,
    input  fall_o,
    input  evt_o
  );

  modport slave (
    input  pin_i,
    input  evt_clr_i,
    output level_o,
    output rise_o,
    output fall_o,
    output evt_o
  );
endinterface

// File: rtl/gpi_debounce_ch.sv
// One GPI channel: synchronizer, tick-based stability filter, edge pulses and sticky flag.
`timescale 1ns/1ps
module gpi_debounce_ch
  import gpi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DEBOUNCE_TICKS = 10,
  parameter logic        INVERT_BIT     = 1'b0,
  parameter logic        RESET_BIT      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pin,
  input  logic evt_clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic evt
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_TICKS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, fall_q;
  logic                   evt_q, evt_d;
  logic                   edge_seen;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync == level_q) begin
      // Any agreement restarts the window, so short glitches never accumulate.
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
        level_d = sync;
        cnt_d   = '0;
      end else begin
        cnt_d = CW'(cnt_q + 1'b1);
      end
    end
  end

  // An edge arriving with a clear keeps the flag set.
  assign edge_seen = rise_q | fall_q;
  assign evt_d     = (evt_q | edge_seen) & ~(evt_clr & ~edge_seen);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{RESET_BIT}};
      cnt_q   <= '0;
      level_q <= RESET_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pin ^ INVERT_BIT};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
      evt_q   <= evt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign evt   = evt_q;

endmodule

// File: rtl/gpi_debounce.sv
// GPI input conditioner: shared tick prescaler plus N_CH independent debounce channels.
`timescale 1ns/1ps
module gpi_debounce
  import gpi_pkg::*;
#(
  parameter int unsigned      N_CH           = 1,
  parameter int unsigned      SYNC_STAGES    = 2,
  parameter int unsigned      TICK_DIV       = TICKS_1MS_48MHZ,
  parameter int unsigned      DEBOUNCE_TICKS = 10,
  parameter logic [N_CH-1:0]  INVERT         = '0,
  parameter logic [N_CH-1:0]  RESET_LEVEL    = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  gpi_debounce_if.slave  bus
);

  logic tick;

  if (TICK_DIV > 1) begin : g_presc
    localparam int unsigned PW = $clog2(TICK_DIV);
    logic [PW-1:0] presc_q;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        presc_q <= '0;
      end else if (tick) begin
        presc_q <= '0;
      end else begin
        presc_q <= PW'(presc_q + 1'b1);
      end
    end
  end else begin : g_no_presc
    assign tick = 1'b1;
  end

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    gpi_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .INVERT_BIT     (INVERT[i]),
      .RESET_BIT      (RESET_LEVEL[i])
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .pin     (bus.pin_i[i]),
      .evt_clr (bus.evt_clr_i[i]),
      .level   (bus.level_o[i]),
      .rise    (bus.rise_o[i]),
      .fall    (bus.fall_o[i]),
      .evt     (bus.evt_o[i])
    );
  end

endmodule

// File: tb/tb_gpi_debounce.sv
// Directed bench for gpi_debounce: latency, bounce rejection, clear race, prescaler, reset.
`timescale 1ns/1ps
module tb_gpi_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errs = 0;
  int   lat;
  logic found;

  always #5 clk = ~clk;

  gpi_debounce_if #(.N_CH(2)) bus_a ();
  gpi_debounce_if #(.N_CH(2)) bus_p ();

  gpi_debounce #(
    .N_CH(2), .SYNC_STAGES(2), .TICK_DIV(1), .DEBOUNCE_TICKS(4),
    .INVERT(2'b01), .RESET_LEVEL(2'b00)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  gpi_debounce #(
    .N_CH(2), .SYNC_STAGES(2), .TICK_DIV(5), .DEBOUNCE_TICKS(2),
    .INVERT(2'b01), .RESET_LEVEL(2'b00)
  ) u_dut_p (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_p)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_a.pin_i = 2'b01;
    bus_a.evt_clr_i = 2'b00;
    bus_p.pin_i = 2'b01;
    bus_p.evt_clr_i = 2'b00;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_level", bus_a.level_o, 2'b00);
    chk("rst_rise", bus_a.rise_o, 2'b00);
    chk("rst_fall", bus_a.fall_o, 2'b00);
    chk("rst_evt", bus_a.evt_o, 2'b00);
    chk("rst_level_p", bus_p.level_o, 2'b00);

    // Release with ch0 pin high: inverted, it matches the reset level.
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("rel_level", bus_a.level_o, 2'b00);
      chk("rel_rise", bus_a.rise_o, 2'b00);
      chk("rel_fall", bus_a.fall_o, 2'b00);
      chk("rel_evt", bus_a.evt_o, 2'b00);
    end

    // Clean press on ch1; k counts edges starting with the sampling edge.
    bus_a.pin_i = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("press_level", bus_a.level_o, (k >= 6) ? 2'b10 : 2'b00);
      chk("press_rise", bus_a.rise_o, (k == 6) ? 2'b10 : 2'b00);
      chk("press_fall", bus_a.fall_o, 2'b00);
      chk("press_evt", bus_a.evt_o, (k >= 7) ? 2'b10 : 2'b00);
    end

    // Release ch1, clearing during the fall pulse and again one cycle later.
    bus_a.pin_i = 2'b01;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("relz_level", bus_a.level_o, (k >= 6) ? 2'b00 : 2'b10);
      chk("relz_fall", bus_a.fall_o, (k == 6) ? 2'b10 : 2'b00);
      chk("relz_evt", bus_a.evt_o, (k <= 7) ? 2'b10 : 2'b00);
      if (k == 6) bus_a.evt_clr_i = 2'b10;
      if (k == 8) bus_a.evt_clr_i = 2'b00;
    end

    // Bounce on ch1: 2-cycle pulses must never be accepted.
    for (int i = 0; i < 8; i++) begin
      bus_a.pin_i = (i % 4 < 2) ? 2'b11 : 2'b01;
      step();
      chk("bnc_level", bus_a.level_o, 2'b00);
      chk("bnc_rise", bus_a.rise_o, 2'b00);
    end
    bus_a.pin_i = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("bnc_final_level", bus_a.level_o, (k >= 6) ? 2'b10 : 2'b00);
      chk("bnc_final_rise", bus_a.rise_o, (k == 6) ? 2'b10 : 2'b00);
      chk("bnc_final_evt", bus_a.evt_o, (k >= 7) ? 2'b10 : 2'b00);
    end

    // ch0 change, then reset while its counter holds 3.
    bus_a.pin_i = 2'b10;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("mid_level", bus_a.level_o, 2'b10);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", bus_a.level_o, 2'b00);
    chk("mid_rst_rise", bus_a.rise_o, 2'b00);
    chk("mid_rst_fall", bus_a.fall_o, 2'b00);
    chk("mid_rst_evt", bus_a.evt_o, 2'b00);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("post_rst_level", bus_a.level_o, (k >= 6) ? 2'b11 : 2'b00);
      chk("post_rst_rise", bus_a.rise_o, (k == 6) ? 2'b11 : 2'b00);
      chk("post_rst_evt", bus_a.evt_o, (k >= 7) ? 2'b11 : 2'b00);
    end

    // Prescaled instance: latency window then a rejected 4-cycle glitch.
    bus_p.pin_i = 2'b00;
    found = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (!found && bus_p.level_o[0]) begin
        found = 1'b1;
        lat = k;
      end
    end
    chk("presc_found", {1'b0, found}, 2'b01);
    chk("presc_lat_in_7_12", {1'b0, (lat >= 7 && lat <= 12)}, 2'b01);
    chk("presc_level", bus_p.level_o, 2'b01);
    bus_p.pin_i = 2'b01;
    for (int k = 1; k <= 24; k++) begin
      if (k == 5) bus_p.pin_i = 2'b00;
      step();
      chk("glitch_level", bus_p.level_o, 2'b01);
      chk("glitch_fall", bus_p.fall_o, 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
